// File: rtl/osd_dii_pkt_arbiter_if.sv
`timescale 1ns/1ps
// Bundle of dii flit sources and the single arbitrated dii flit sink.
// The master modport is the arbiter side; slave is the sources/sink side.
interface osd_dii_pkt_arbiter_if #(
  parameter int NUM_PORTS = 2
);
  logic [NUM_PORTS-1:0]       in_valid;
  logic [NUM_PORTS-1:0]       in_last;
  logic [NUM_PORTS-1:0][15:0] in_data;
  logic [NUM_PORTS-1:0]       in_ready;
  logic                       out_valid;
  logic                       out_last;
  logic [15:0]                out_data;
  logic                       out_ready;

  modport master (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_last, out_data
  );

  modport slave (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_last, out_data
  );
endinterface

// File: rtl/osd_dii_pkt_arbiter.sv
`timescale 1ns/1ps
// Packet-granular round-robin arbiter: grant locks until the winner's last flit.
// Optional oversize-packet check is enabled by defining OSD_DII_ARB_LEN_CHECK_EN.
module osd_dii_pkt_arbiter #(
  parameter int NUM_PORTS   = 2,
  parameter int MAX_PKT_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  osd_dii_pkt_arbiter_if.master dii,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 err_oversize
);
  localparam int PTR_W = $clog2(NUM_PORTS);

  if (NUM_PORTS < 2 || NUM_PORTS > 16 || MAX_PKT_LEN < 3) begin : g_param_check
    $error("osd_dii_pkt_arbiter: illegal NUM_PORTS or MAX_PKT_LEN");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOCKED = 2'd1
`ifdef OSD_DII_ARB_LEN_CHECK_EN
    , S_DRAIN = 2'd2
`endif
  } state_t;

  state_t               r_state, w_state_next;
  logic [NUM_PORTS-1:0] r_grant, w_grant_next;
  logic [PTR_W-1:0]     r_gidx, w_gidx_next;
  logic [PTR_W-1:0]     r_rr_ptr, w_rr_next;
  logic [PTR_W-1:0]     w_pick_idx;
  logic [PTR_W-1:0]     w_gidx_inc;
  logic                 w_pick_found;
  logic                 w_sel_valid;
  logic                 w_sel_last;
  logic                 w_xfer;

`ifdef OSD_DII_ARB_LEN_CHECK_EN
  localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             w_err;
  assign err_oversize = w_err;
`else
  assign err_oversize = 1'b0;
`endif

  // Scan downward so the candidate closest to rr_ptr is the one left standing.
  always_comb begin
    int j;
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      j = int'(r_rr_ptr) + k;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (dii.in_valid[j]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = PTR_W'(j);
      end
    end
  end

  assign w_sel_valid = dii.in_valid[r_gidx];
  assign w_sel_last  = dii.in_last[r_gidx];
  assign w_gidx_inc  = (r_gidx == PTR_W'(NUM_PORTS - 1)) ? '0 : r_gidx + 1'b1;
  assign w_xfer      = (r_state == S_LOCKED) && w_sel_valid && dii.out_ready;
  assign grant       = r_grant;

  always_comb begin
    w_state_next  = r_state;
    w_grant_next  = r_grant;
    w_gidx_next   = r_gidx;
    w_rr_next     = r_rr_ptr;
    dii.in_ready  = '0;
    dii.out_valid = 1'b0;
    dii.out_last  = 1'b0;
    dii.out_data  = dii.in_data[r_gidx];
`ifdef OSD_DII_ARB_LEN_CHECK_EN
    w_cnt_next    = r_cnt;
    w_err         = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_pick_found) begin
          w_state_next = S_LOCKED;
          w_grant_next = NUM_PORTS'(1) << w_pick_idx;
          w_gidx_next  = w_pick_idx;
`ifdef OSD_DII_ARB_LEN_CHECK_EN
          w_cnt_next   = '0;
`endif
        end
      end
      S_LOCKED: begin
        dii.out_valid = w_sel_valid;
        dii.out_last  = w_sel_last;
        dii.in_ready  = r_grant & {NUM_PORTS{dii.out_ready}};
        if (w_xfer && w_sel_last) begin
          w_state_next = S_IDLE;
          w_grant_next = '0;
          w_rr_next    = w_gidx_inc;
        end
`ifdef OSD_DII_ARB_LEN_CHECK_EN
        else if (w_xfer) begin
          w_cnt_next = r_cnt + 1'b1;
          // Truncate: close the packet downstream, then swallow the rest.
          if (r_cnt == CNT_W'(MAX_PKT_LEN - 1)) begin
            dii.out_last = 1'b1;
            w_err        = 1'b1;
            w_state_next = S_DRAIN;
          end
        end
`endif
      end
`ifdef OSD_DII_ARB_LEN_CHECK_EN
      S_DRAIN: begin
        dii.in_ready = r_grant;
        if (w_sel_valid && w_sel_last) begin
          w_state_next = S_IDLE;
          w_grant_next = '0;
          w_rr_next    = w_gidx_inc;
        end
      end
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_gidx   <= '0;
      r_rr_ptr <= '0;
`ifdef OSD_DII_ARB_LEN_CHECK_EN
      r_cnt    <= '0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_grant  <= w_grant_next;
      r_gidx   <= w_gidx_next;
      r_rr_ptr <= w_rr_next;
`ifdef OSD_DII_ARB_LEN_CHECK_EN
      r_cnt    <= w_cnt_next;
`endif
    end
  end
endmodule
